// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (CPU / debug loader) arbiter in front of a single-port
// data memory with one-cycle read latency. CPU has priority; when the
// MEM_ARB_FAIRNESS_EN macro is defined, a saturating hold counter lets the
// debug port in after MAX_HOLD consecutive CPU grants made while it waited.
// Without the macro the CPU has strict priority and debug may starve.
module mem_arbiter #(
   parameter int ADDR_W   = 6,
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              reset,
   // CPU port
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_valid,
   output logic [DATA_W-1:0] cpu_rdata,
   // debug / loader port
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_valid,
   output logic [DATA_W-1:0] dbg_rdata,
   // data memory side
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out,
   // CPU is requesting but not being served this cycle
   output logic              stall_cpu
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

   state_t              state_q, state_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                port_q, port_d;
   logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;

   logic                arb_edge;
   logic                dbg_wins;
   logic                in_grant;
   logic                in_resp;

   // A new winner is chosen when leaving IDLE, a write GRANT, or RESP.
   // A read GRANT always continues into RESP first.
   assign arb_edge = (state_q == IDLE) || (state_q == RESP) ||
                     ((state_q == GRANT) && we_q);

`ifdef MEM_ARB_FAIRNESS_EN
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);

   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;

   // Debug overrides CPU once the CPU has been served MAX_HOLD times in a row
   // while debug was waiting.
   assign dbg_wins = dbg_req && (!cpu_req || (hold_cnt_q == HOLD_W'(MAX_HOLD)));

   // Hold counter next state: count CPU wins over a waiting debug port.
   always_comb begin
      hold_cnt_d = hold_cnt_q;
      if (arb_edge) begin
         if (!dbg_req || dbg_wins) begin
            hold_cnt_d = '0;
         end else if (cpu_req && (hold_cnt_q != HOLD_W'(MAX_HOLD))) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
         end
      end
   end

   // Hold counter register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         hold_cnt_q <= '0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
      end
   end
`else
   // Strict CPU priority: debug is served only when the CPU is not asking.
   assign dbg_wins = dbg_req && !cpu_req;
`endif

   // FSM next state, command capture at arbitration edges, read data capture.
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      port_d      = port_q;
      cpu_rdata_d = cpu_rdata_q;
      dbg_rdata_d = dbg_rdata_q;

      case (state_q)
         IDLE:    state_d = IDLE;
         GRANT:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (arb_edge) begin
         if (dbg_wins) begin
            state_d = GRANT;
            port_d  = PORT_DBG;
            we_d    = dbg_we;
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
         end else if (cpu_req) begin
            state_d = GRANT;
            port_d  = PORT_CPU;
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
         end else begin
            state_d = IDLE;
         end
      end

      // Keep the returned word so rdata holds after the valid pulse.
      if (state_q == RESP) begin
         if (port_q == PORT_CPU) begin
            cpu_rdata_d = mem_data_out;
         end else begin
            dbg_rdata_d = mem_data_out;
         end
      end
   end

   // State and captured-command registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         port_q      <= PORT_CPU;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         port_q      <= port_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

   // Handshakes are qualified by reset so that asserting reset in the
   // middle of an access suppresses its grant/valid in that very cycle.
   assign in_grant = (state_q == GRANT) && reset;
   assign in_resp  = (state_q == RESP)  && reset;

   assign cpu_gnt     = in_grant && (port_q == PORT_CPU);
   assign dbg_gnt     = in_grant && (port_q == PORT_DBG);
   assign cpu_valid   = in_resp  && (port_q == PORT_CPU);
   assign dbg_valid   = in_resp  && (port_q == PORT_DBG);
   assign cpu_rdata   = cpu_valid ? mem_data_out : cpu_rdata_q;
   assign dbg_rdata   = dbg_valid ? mem_data_out : dbg_rdata_q;

   assign mem_write   = in_grant && we_q;
   assign mem_read    = in_grant && !we_q;
   assign mem_addr    = in_grant ? addr_q  : '0;
   assign mem_data_in = in_grant ? wdata_q : '0;

   assign stall_cpu   = cpu_req && !cpu_gnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios push expected grant/valid
// events into a scoreboard queue; a negedge monitor pops and compares them.
module tb_mem_arbiter;

   localparam int AW = 6;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_req, cpu_we, dbg_req, dbg_we;
   logic [AW-1:0] cpu_addr, dbg_addr;
   logic [DW-1:0] cpu_wdata, dbg_wdata;
   logic          cpu_gnt, cpu_valid, dbg_gnt, dbg_valid;
   logic [DW-1:0] cpu_rdata, dbg_rdata;
   logic          mem_read, mem_write, stall_cpu;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data_in, mem_data_out;
   logic [DW-1:0] tb_mem [0:(1<<AW)-1];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_rd_gnt = -10;

   typedef struct {
      logic          is_valid;
      logic          port;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   mon_n;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(4)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_valid(dbg_valid), .dbg_rdata(dbg_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .stall_cpu(stall_cpu)
   );

   // Data memory model: pattern fill on reset, one-cycle registered read.
   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < (1 << AW); i++) tb_mem[i] <= 8'(i) ^ 8'h3C;
         mem_data_out <= '0;
      end else begin
         if (mem_write) tb_mem[mem_addr] <= mem_data_in;
         if (mem_read)  mem_data_out <= tb_mem[mem_addr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push(input logic v, input logic p, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_t e;
      e.is_valid = v; e.port = p; e.we = w; e.addr = a; e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic cpu_op(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cpu_we = w; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (cpu_gnt) begin
            cpu_req = 1'b0;
            return;
         end
      end
      checks++; failures++;
      $display("FAIL cpu_gnt_timeout: got no grant in 60 cycles required grant addr 0x%0h", a);
      cpu_req = 1'b0;
   endtask

   task automatic dbg_op(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      dbg_we = w; dbg_addr = a; dbg_wdata = d; dbg_req = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (dbg_gnt) begin
            dbg_req = 1'b0;
            return;
         end
      end
      checks++; failures++;
      $display("FAIL dbg_gnt_timeout: got no grant in 60 cycles required grant addr 0x%0h", a);
      dbg_req = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every grant/valid is matched in order against the scoreboard.
   always @(negedge clk) begin
      cyc++;
      mon_n = int'(cpu_gnt) + int'(dbg_gnt) + int'(cpu_valid) + int'(dbg_valid);
      if (mon_n > 0) begin
         chk("one_handshake_per_cycle", mon_n, 1);
         if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_event: got cg=%b dg=%b cv=%b dv=%b mw=%b mr=%b addr=0x%0h required none",
                     cpu_gnt, dbg_gnt, cpu_valid, dbg_valid, mem_write, mem_read, mem_addr);
         end else begin
            mon_e = exp_q.pop_front();
            chk("event_kind_port", {cpu_valid | dbg_valid, dbg_gnt | dbg_valid},
                {mon_e.is_valid, mon_e.port});
            if (!mon_e.is_valid) begin
               chk("gnt_mem_write", mem_write, mon_e.we);
               chk("gnt_mem_read", mem_read, !mon_e.we);
               chk("gnt_mem_addr", mem_addr, mon_e.addr);
               if (mon_e.we) chk("gnt_mem_data_in", mem_data_in, mon_e.data);
               else last_rd_gnt = cyc;
            end else begin
               chk("valid_rdata", mon_e.port ? dbg_rdata : cpu_rdata, mon_e.data);
               chk("read_latency", cyc - last_rd_gnt, 1);
               chk("resp_mem_bus_idle", {mem_read, mem_write, mem_addr, mem_data_in}, 0);
            end
         end
      end else begin
         chk("idle_mem_bus", {mem_read, mem_write, mem_addr, mem_data_in}, 0);
      end
   end

   // Hard time limit so the run can never hang.
   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish required finish before 200000");
      $fatal(1, "timeout");
   end

   // Directed scenarios.
   initial begin
      reset = 1'b0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_handshakes", {cpu_gnt, dbg_gnt, cpu_valid, dbg_valid, stall_cpu}, 0);
      chk("reset_rdata", {cpu_rdata, dbg_rdata}, 0);
      @(posedge clk); #1;
      reset = 1'b1;

      // CPU write 0x05=0xA7 then read it back, back to back.
      push(0, 0, 1, 6'h05, 8'hA7);
      push(0, 0, 0, 6'h05, 8'h00);
      push(1, 0, 0, 6'h05, 8'hA7);
      cpu_op(1, 6'h05, 8'hA7);
      cpu_op(0, 6'h05, 8'h00);
      idle(4);
      chk("cpu_rdata_holds", cpu_rdata, 8'hA7);

      // Simultaneous requests: CPU read 0x10 first, then debug write 0x3F=0x5A.
      push(0, 0, 0, 6'h10, 8'h00);
      push(1, 0, 0, 6'h10, 8'h2C);
      push(0, 1, 1, 6'h3F, 8'h5A);
      push(0, 1, 0, 6'h3F, 8'h00);
      push(1, 1, 0, 6'h3F, 8'h5A);
      fork
         cpu_op(0, 6'h10, 8'h00);
         dbg_op(1, 6'h3F, 8'h5A);
      join
      dbg_op(0, 6'h3F, 8'h00);
      idle(4);

      // Continuous CPU writes while debug waits.
`ifdef MEM_ARB_FAIRNESS_EN
      for (int i = 0; i < 4; i++) push(0, 0, 1, 6'(i), 8'(8'h40 + i));
      push(0, 1, 1, 6'h3E, 8'h77);
      for (int i = 4; i < 6; i++) push(0, 0, 1, 6'(i), 8'(8'h40 + i));
`else
      for (int i = 0; i < 6; i++) push(0, 0, 1, 6'(i), 8'(8'h40 + i));
      push(0, 1, 1, 6'h3E, 8'h77);
`endif
      fork
         begin
            for (int i = 0; i < 6; i++) cpu_op(1, 6'(i), 8'(8'h40 + i));
         end
         dbg_op(1, 6'h3E, 8'h77);
      join
      idle(3);

      // Reset asserted in the RESP cycle of a debug read of 0x20.
      push(0, 1, 0, 6'h20, 8'h00);
      dbg_op(0, 6'h20, 8'h00);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("no_valid_under_reset", {cpu_valid, dbg_valid}, 0);
      @(posedge clk); #1;
      chk("abort_handshakes", {cpu_gnt, dbg_gnt, cpu_valid, dbg_valid, stall_cpu}, 0);
      chk("abort_mem_bus", {mem_read, mem_write, mem_addr, mem_data_in}, 0);
      chk("abort_rdata", {cpu_rdata, dbg_rdata}, 0);
      reset = 1'b1;
      idle(4);

      // CPU request raised and dropped while debug holds the memory.
      push(0, 1, 0, 6'h21, 8'h00);
      push(1, 1, 0, 6'h21, 8'h1D);
      dbg_op(0, 6'h21, 8'h00);
      cpu_we = 1'b1; cpu_addr = 6'h11; cpu_wdata = 8'hEE; cpu_req = 1'b1;
      #1;
      chk("stall_in_dbg_grant", stall_cpu, 1);
      @(negedge clk);
      chk("stall_in_dbg_resp", stall_cpu, 1);
      cpu_req = 1'b0;
      #1;
      chk("stall_after_drop", stall_cpu, 0);
      idle(4);
      chk("dropped_cpu_write_absent", tb_mem[6'h11], 8'h2D);

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
